// File: rtl/uart_tx_buffered.sv
// Buffered UART 8N1 transmitter: a {last,data} FIFO feeding a start/data/stop
// serialiser, LSB first, with a one-cycle done pulse after a last-tagged stop bit.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_en,
    input  logic [7:0]       w_data,
    input  logic             w_last,
    input  logic             w_valid,
    output logic             w_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             done,
    output logic [1:0]       state_dbg
);
    // Write handshake: a byte is taken on a rising edge where w_valid && w_ready;
    // w_ready depends only on the FIFO fill level, never on w_valid.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, fifo_empty, baud_end;
    logic [8:0]       head;

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             last_q, last_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    assign w_ready    = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = w_valid && w_ready;
    assign baud_end   = (baud_q == BAUD_LAST);
    assign head       = mem_q[rd_ptr_q];

    // Pop decisions happen only from IDLE or on the final cycle of a stop bit.
    assign pop = !fifo_empty && tx_en &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {w_last, w_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    shift_d = head[7:0];
                    last_d  = head[8];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    done_d = last_q;
                    if (pop) begin
                        state_d = S_START;
                        shift_d = head[7:0];
                        last_d  = head[8];
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign fifo_count = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a queue-and-frame-position model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_buffered;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_en = 1'b0;
  logic [7:0]    w_data = 8'h00;
  logic          w_last = 1'b0;
  logic          w_valid = 1'b0;
  wire           w_ready;
  wire           tx;
  wire           busy;
  wire           done;
  wire [CW-1:0]  fifo_count;
  wire [1:0]     state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit run_cmp = 1'b0;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .w_data(w_data), .w_last(w_last),
    .w_valid(w_valid), .w_ready(w_ready), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // model: queue of {last,data} plus position within the frame on the line
  logic [8:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [8:0] m_cur = 9'h000;
  bit         m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_pos = 0;
      m_done = 1'b0;
    end else begin
      bit full, has, frame_end, push;
      full = (mq.size() == DEPTH);
      has = (mq.size() != 0);
      push = w_valid && !full;
      frame_end = m_active && (m_pos == FRAME - 1);
      m_done = frame_end && m_cur[8];
      if ((!m_active || frame_end) && has && tx_en) begin
        m_cur = mq.pop_front();
        m_active = 1'b1;
        m_pos = 0;
      end else if (frame_end) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_pos++;
      end
      if (push) mq.push_back({w_last, w_data});
    end
  end

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_pos < CPB) return 1'b0;
    if (m_pos < 9 * CPB) return m_cur[m_pos / CPB - 1];
    return 1'b1;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_tx", 32'(tx), 32'(exp_tx()));
      check("model_busy", 32'(busy), 32'(m_active));
      check("model_done", 32'(done), 32'(m_done));
      check("model_count", 32'(fifo_count), 32'(mq.size()));
      check("model_ready", 32'(w_ready), 32'(mq.size() < DEPTH));
    end
  end

  // driver: called at a negedge, returns at the negedge after the write edge
  task automatic write_byte(input logic [7:0] d, input logic l);
    w_valid = 1'b1;
    w_data = d;
    w_last = l;
    @(posedge clk);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  initial begin
    int w, ndone, done_at, nbusy, k, nlow;
    logic [9:0] bits;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(w_ready), 1);
    check("rst_count", 32'(fifo_count), 0);
    rst_n = 1'b1;
    run_cmp = 1'b1;
    tx_en = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5
    write_byte(8'hA5, 1'b1);
    w = cyc;
    check("a5_idle_at_write", 32'(tx), 1);
    bits = '0; ndone = 0; done_at = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) check("a5_fall_latency", 32'(tx), 0);
      if (((cyc - w - 1) % CPB == 2) && ((cyc - w - 1) / CPB < 10)) bits[(cyc - w - 1) / CPB] = tx;
      if (done) begin ndone++; done_at = cyc - w; end
    end
    check("a5_bits", 32'(bits), 32'h34A);
    check("a5_done_count", 32'(ndone), 1);
    check("a5_done_cycle", 32'(done_at), 41);
    check("a5_busy_after", 32'(busy), 0);

    // back-to-back 0x00, 0xFF, 0x3C
    write_byte(8'h00, 1'b0);
    write_byte(8'hFF, 1'b0);
    write_byte(8'h3C, 1'b1);
    w = cyc;
    check("b2b_count_after_writes", 32'(fifo_count), 2);
    nbusy = 0; ndone = 0; done_at = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin ndone++; done_at = cyc - w; end
    end
    check("b2b_busy_cycles", 32'(nbusy), 118);
    check("b2b_done_count", 32'(ndone), 1);
    check("b2b_done_cycle", 32'(done_at), 119);

    // full FIFO with tx_en low
    tx_en = 1'b0;
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    write_byte(8'h44, 1'b1);
    check("full_ready_low", 32'(w_ready), 0);
    write_byte(8'h55, 1'b1);
    check("full_count", 32'(fifo_count), 4);
    check("full_idle", 32'(busy), 0);
    tx_en = 1'b1;
    ndone = 0;
    for (int i = 0; i < 4 * FRAME + 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("full_frames", 32'(ndone), 4);
    check("full_drained", 32'(fifo_count), 0);

    // tx_en drop during DATA of frame 1
    write_byte(8'hAA, 1'b1);
    write_byte(8'hBB, 1'b1);
    write_byte(8'hCC, 1'b1);
    repeat (6) @(negedge clk);
    tx_en = 1'b0;
    check("drop_count_queued", 32'(fifo_count), 2);
    k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("drop_frame_end", 32'(k), 33);
    check("drop_tx_high", 32'(tx), 1);
    check("drop_count_kept", 32'(fifo_count), 2);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    check("drop_no_pop", 32'(nbusy), 0);
    tx_en = 1'b1;
    ndone = 0;
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("drop_resume_frames", 32'(ndone), 2);

    // reset during data bit 3
    write_byte(8'h5A, 1'b1);
    write_byte(8'h66, 1'b1);
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_count", 32'(fifo_count), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nlow = 0; ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) nlow++;
      if (done) ndone++;
    end
    check("midrst_line_idle", 32'(nlow), 0);
    check("midrst_no_done", 32'(ndone), 0);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
